d8m_init_sequencer: RTL and testbench
=====================================

# d8m_init_sequencer

Power-up and register-configuration sequencer for the D8M camera path. It drives the MIPI bridge power-down and reset pins through their timed release. It then walks an external synchronous configuration ROM and issues each entry as a write request to a shared I2C master over a req/ack handshake. Completion or failure is flagged to the Nios software and to the camera capture front end. It sits between the Qsys PIO outputs for MIPI pwdn/reset and the I2C opencores masters.

## Interface
Parameters:
- PWDN_CYCLES, 5000: clocks with pwdn_n=0 and mipi_reset_n=0 after start.
- RESET_CYCLES, 5000: clocks with pwdn_n=1 and mipi_reset_n=0.
- BOOT_CYCLES, 50000: clocks after full release, before the first ROM fetch.
- ROM_AW, 8: ROM address width; depth is 2^ROM_AW.
- RETRY_MAX, 3: extra attempts allowed per NACKed entry.

Ports:
- clk  in  1  system clock, 50 MHz.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse that begins the sequence.
- pwdn_n  out  1  MIPI bridge power-down, active low.
- mipi_reset_n  out  1  MIPI bridge reset, active low.
- rom_addr  out  ROM_AW  ROM address.
- rom_data  in  40  ROM word, valid 1 clock after rom_addr: [39] last flag, [38:32] device address, [31:16] register address, [15:0] data.
- cfg_req  out  1  write request to the I2C master.
- cfg_dev  out  7  device address.
- cfg_reg  out  16  register address.
- cfg_data  out  16  write data.
- cfg_ack  in  1  1-cycle pulse: write completed.
- cfg_nack  in  1  1-cycle pulse: write failed.
- busy  out  1  high from start until DONE or ERR.
- done  out  1  sticky success flag.
- error  out  1  sticky failure flag.
- err_index  out  ROM_AW  ROM index of the failing entry.

## Operation
- States: IDLE, PWDN, RST, BOOT, FETCH, LATCH, ISSUE, DELAY, DONE, ERR.
- IDLE: outputs stay at reset values. Start -> PWDN, rom_addr=0, done=0, error=0.
- PWDN: pwdn_n=0, mipi_reset_n=0 for PWDN_CYCLES, then -> RST.
- RST: pwdn_n=1, mipi_reset_n=0 for RESET_CYCLES, then -> BOOT.
- BOOT: both pins 1 for BOOT_CYCLES, then -> FETCH. The pins remain 1 in every later state except IDLE after reset.
- FETCH: drive rom_addr, then -> LATCH.
- LATCH: register the rom_data fields.
  - Device address 7'h00 is a delay entry -> DELAY.
  - Any other device address -> ISSUE with the retry count cleared.
- DELAY: wait data×1024 clocks; data=0 means no wait. Then go to the next entry.
- ISSUE: cfg_req=1, with cfg_dev/cfg_reg/cfg_data held stable.
  - On cfg_ack: drop cfg_req on the next clock and go to the next entry.
  - On cfg_nack: drop cfg_req. If the retry count is below RETRY_MAX, increment it and re-assert cfg_req after 1 idle clock. Otherwise -> ERR.
  - cfg_ack and cfg_nack high together count as a NACK.
- Next entry: if the last flag is set, or rom_addr = 2^ROM_AW−1 → DONE. Otherwise increment rom_addr and -> FETCH. rom_addr never wraps.
- DONE: done=1, busy=0.
- ERR: error=1, busy=0, err_index = failing rom_addr. pwdn_n and mipi_reset_n are kept high.
- start while busy is ignored. start in DONE or ERR restarts from PWDN and clears done, error and err_index.

## Timing
- All outputs reset asynchronously: pwdn_n=0, mipi_reset_n=0, cfg_req=0, cfg_*=0, rom_addr=0, busy=0, done=0, error=0, err_index=0.
- busy rises the clock after start is sampled.
- pwdn_n rises exactly PWDN_CYCLES clocks after busy rises. mipi_reset_n rises exactly RESET_CYCLES clocks later.
- First rom_addr is presented BOOT_CYCLES clocks after mipi_reset_n rises.
- cfg_req asserts 2 clocks after rom_addr is presented (FETCH, LATCH).
- cfg_req deasserts 1 clock after ack or nack is sampled.
- Delay counter is 26 bits wide (16-bit data × 1024).
- Reset mid-sequence aborts immediately; pins return low.

## Configuration
- D8M_SEQ_RETRY_EN defined: NACK retry as described, up to RETRY_MAX extra attempts.
- Not defined: the first NACK goes directly to ERR. The retry counter and its logic are not built, and RETRY_MAX is unused.

## Test plan
- PWDN_CYCLES=4, RESET_CYCLES=4, BOOT_CYCLES=8; pulse start -> pwdn_n rises 4 clocks after busy, mipi_reset_n 4 clocks later, rom_addr 0 presented 8 clocks after that.
- ROM holds 3 writes, entry 2 has the last flag, bench ACKs after 5 clocks -> exactly 3 cfg_req pulses with ROM-matching fields, then done=1, busy=0.
- Entry 1 is a delay with data=2 -> exactly 2048 idle clocks between the ACK of entry 0 and the fetch of entry 2.
- Entry 1 NACKed 4 times with RETRY_MAX=3 and the macro defined -> 4 cfg_req pulses, error=1, err_index=1. Without the macro: 1 pulse, then ERR.
- Simultaneous ack+nack on entry 0 -> treated as NACK and retried. Separately, reset_n low during ISSUE -> cfg_req=0 and pins low asynchronously.
- No last flag with ROM_AW=2 -> entries 0..3 are issued, then DONE with no wrap. start during busy has no effect.

Source files
------------

// File: rtl/d8m_init_sequencer.sv
// D8M camera power-up and register-configuration sequencer.
// Releases MIPI bridge pwdn/reset in timed steps, then walks a
// synchronous config ROM and issues each entry to an I2C master
// over cfg_req/cfg_ack/cfg_nack. busy/done/error report status;
// err_index holds the ROM index of a failing entry.
// Ports: clk, reset_n, start, pwdn_n, mipi_reset_n, rom_addr,
// rom_data, cfg_req, cfg_dev, cfg_reg, cfg_data, cfg_ack, cfg_nack,
// busy, done, error, err_index.
// Build option: D8M_SEQ_RETRY_EN enables NACK retries (RETRY_MAX).
module d8m_init_sequencer #(
  parameter int PWDN_CYCLES  = 5000,
  parameter int RESET_CYCLES = 5000,
  parameter int BOOT_CYCLES  = 50000,
  parameter int ROM_AW       = 8,
  parameter int RETRY_MAX    = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic              pwdn_n,
  output logic              mipi_reset_n,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [39:0]       rom_data,
  output logic              cfg_req,
  output logic [6:0]        cfg_dev,
  output logic [15:0]       cfg_reg,
  output logic [15:0]       cfg_data,
  input  logic              cfg_ack,
  input  logic              cfg_nack,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ROM_AW-1:0] err_index
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_PWDN,
    S_RST,
    S_BOOT,
    S_FETCH,
    S_LATCH,
    S_ISSUE,
    S_DELAY,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [25:0] PWDN_LD  = 26'(PWDN_CYCLES - 1);
  localparam logic [25:0] RESET_LD = 26'(RESET_CYCLES - 1);
  localparam logic [25:0] BOOT_LD  = 26'(BOOT_CYCLES - 1);

  state_t      state;
  state_t      state_n;
  logic [25:0] cnt;
  logic        last;
  logic        gap;
  logic        can_retry;
  logic        end_now;
  logic        at_end;
  logic        is_delay;

`ifdef D8M_SEQ_RETRY_EN
  localparam int RW = $clog2(RETRY_MAX + 2);
  localparam logic [RW-1:0] RMAX = RW'(RETRY_MAX);
  logic [RW-1:0] retry;
  assign can_retry = (retry < RMAX);
`else
  assign can_retry = 1'b0;
  assign gap       = 1'b0;
`endif

  assign is_delay = (rom_data[38:32] == 7'h00);
  // In LATCH the last flag is still on rom_data, not yet in last.
  assign end_now  = (state == S_LATCH) ? rom_data[39] : last;
  assign at_end   = end_now | (&rom_addr);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n      = state;
    pwdn_n       = 1'b1;
    mipi_reset_n = 1'b1;
    busy         = 1'b1;
    done         = 1'b0;
    error        = 1'b0;
    cfg_req      = 1'b0;
    unique case (state)
      S_IDLE: begin
        pwdn_n       = 1'b0;
        mipi_reset_n = 1'b0;
        busy         = 1'b0;
        if (start) state_n = S_PWDN;
      end
      S_PWDN: begin
        pwdn_n       = 1'b0;
        mipi_reset_n = 1'b0;
        if (cnt == '0) state_n = S_RST;
      end
      S_RST: begin
        mipi_reset_n = 1'b0;
        if (cnt == '0) state_n = S_BOOT;
      end
      S_BOOT: begin
        if (cnt == '0) state_n = S_FETCH;
      end
      S_FETCH: state_n = S_LATCH;
      S_LATCH: begin
        if (!is_delay)
          state_n = S_ISSUE;
        else if (rom_data[15:0] != 16'h0)
          state_n = S_DELAY;
        else
          state_n = at_end ? S_DONE : S_FETCH;
      end
      S_DELAY: begin
        if (cnt == '0)
          state_n = at_end ? S_DONE : S_FETCH;
      end
      S_ISSUE: begin
        cfg_req = ~gap;
        if (!gap) begin
          if (cfg_nack)
            state_n = can_retry ? S_ISSUE : S_ERR;
          else if (cfg_ack)
            state_n = at_end ? S_DONE : S_FETCH;
        end
      end
      S_DONE: begin
        busy = 1'b0;
        done = 1'b1;
        if (start) state_n = S_PWDN;
      end
      S_ERR: begin
        busy  = 1'b0;
        error = 1'b1;
        if (start) state_n = S_PWDN;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt       <= '0;
      rom_addr  <= '0;
      last      <= 1'b0;
      cfg_dev   <= '0;
      cfg_reg   <= '0;
      cfg_data  <= '0;
      err_index <= '0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            cnt       <= PWDN_LD;
            rom_addr  <= '0;
            err_index <= '0;
          end
        end
        S_PWDN:  cnt <= (cnt == '0) ? RESET_LD : cnt - 26'd1;
        S_RST:   cnt <= (cnt == '0) ? BOOT_LD : cnt - 26'd1;
        S_BOOT:  cnt <= cnt - 26'd1;
        S_LATCH: begin
          last <= rom_data[39];
          if (is_delay) begin
            cnt <= {rom_data[15:0], 10'd0} - 26'd1;
          end else begin
            cfg_dev  <= rom_data[38:32];
            cfg_reg  <= rom_data[31:16];
            cfg_data <= rom_data[15:0];
          end
        end
        S_DELAY: cnt <= cnt - 26'd1;
        default: ;
      endcase
      // Every "next entry" move lands in FETCH from a non-BOOT state.
      if (state_n == S_FETCH && state != S_BOOT)
        rom_addr <= rom_addr + 1'b1;
      if (state_n == S_ERR && state != S_ERR)
        err_index <= rom_addr;
    end
  end

`ifdef D8M_SEQ_RETRY_EN
  // gap holds cfg_req low for one clock between attempts.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      retry <= '0;
      gap   <= 1'b0;
    end else if (state == S_LATCH) begin
      retry <= '0;
      gap   <= 1'b0;
    end else if (state == S_ISSUE) begin
      if (gap) begin
        gap <= 1'b0;
      end else if (cfg_nack && can_retry) begin
        retry <= retry + 1'b1;
        gap   <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_d8m_init_sequencer.sv
// Directed bench for d8m_init_sequencer with a ROM model,
// an I2C responder and a scoreboard of expected cfg writes.
module tb_d8m_init_sequencer;

  localparam int AW = 2;
  localparam int ACK_WAIT = 5;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic          pwdn_n;
  logic          mipi_reset_n;
  logic [AW-1:0] rom_addr;
  logic [39:0]   rom_data;
  logic          cfg_req;
  logic [6:0]    cfg_dev;
  logic [15:0]   cfg_reg;
  logic [15:0]   cfg_data;
  logic          cfg_ack;
  logic          cfg_nack;
  logic          busy;
  logic          done;
  logic          error;
  logic [AW-1:0] err_index;

  logic [39:0] rom [4];
  int cyc = 0;
  int tests = 0;
  int fails = 0;
  logic [38:0] exp_q [$];
  int script [$];
  int npulse = 0;
  int last_rise = 0;
  int ack_cyc = 0;

  d8m_init_sequencer #(
    .PWDN_CYCLES(4), .RESET_CYCLES(4), .BOOT_CYCLES(8),
    .ROM_AW(AW), .RETRY_MAX(3)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .pwdn_n(pwdn_n), .mipi_reset_n(mipi_reset_n),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .cfg_req(cfg_req), .cfg_dev(cfg_dev), .cfg_reg(cfg_reg),
    .cfg_data(cfg_data), .cfg_ack(cfg_ack), .cfg_nack(cfg_nack),
    .busy(busy), .done(done), .error(error),
    .err_index(err_index)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rom_data <= rom[rom_addr];

  function automatic logic [39:0] mk(input logic l, input logic [6:0] d,
                                     input logic [15:0] r, input logic [15:0] v);
    return {l, d, r, v};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic sig(input int s);
    case (s)
      0: return busy;
      1: return pwdn_n;
      2: return mipi_reset_n;
      3: return cfg_req;
      4: return done;
      5: return error;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_sig(input int s, input int lim, input string tag,
                          output int at);
    int n = 0;
    while (sig(s) !== 1'b1 && n < lim) begin
      @(negedge clk);
      n++;
    end
    at = cyc;
    check(tag, 64'(sig(s)), 64'd1);
  endtask

  task automatic wait_pulses(input int target, input int lim,
                             input string tag);
    int n = 0;
    while (npulse < target && n < lim) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(npulse), 64'(target));
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Responder and scoreboard: compares each new cfg_req pulse
  // against the expected queue and answers per the script.
  task automatic monitor();
    logic req_prev = 1'b0;
    logic chk_drop = 1'b0;
    int resp_cnt = 0;
    int kind = 0;
    logic [38:0] e;
    forever begin
      @(negedge clk);
      cfg_ack  = 1'b0;
      cfg_nack = 1'b0;
      if (!reset_n) begin
        req_prev = 1'b0;
        chk_drop = 1'b0;
        resp_cnt = 0;
      end else begin
        if (chk_drop) begin
          chk_drop = 1'b0;
          check("req_drop", 64'(cfg_req), 64'd0);
        end
        if (cfg_req && !req_prev) begin
          npulse++;
          last_rise = cyc;
          if (exp_q.size() == 0) begin
            check("unexpected_req", 64'd1, 64'd0);
          end else begin
            e = exp_q.pop_front();
            check("req_fields", 64'({cfg_dev, cfg_reg, cfg_data}),
                  64'(e));
          end
          kind = (script.size() != 0) ? script.pop_front() : 0;
          resp_cnt = ACK_WAIT;
        end
        req_prev = cfg_req;
        if (resp_cnt > 0) begin
          resp_cnt--;
          if (resp_cnt == 0) begin
            cfg_ack  = (kind == 0 || kind == 2);
            cfg_nack = (kind == 1 || kind == 2);
            ack_cyc  = cyc + 1;
            chk_drop = 1'b1;
          end
        end
      end
    end
  endtask

  initial begin
    logic [39:0] w0, w1, w2, w2n, w3, dly;
    int tb, tp, tm, tr, base, n;
    w0  = mk(1'b0, 7'h3C, 16'h3008, 16'h0082);
    w1  = mk(1'b0, 7'h3C, 16'h3103, 16'h0011);
    w2  = mk(1'b1, 7'h36, 16'h0100, 16'hBEEF);
    w2n = mk(1'b0, 7'h36, 16'h0100, 16'hBEEF);
    w3  = mk(1'b0, 7'h10, 16'hABCD, 16'h5A5A);
    dly = mk(1'b0, 7'h00, 16'h0000, 16'h0002);
    reset_n  = 1'b0;
    start    = 1'b0;
    cfg_ack  = 1'b0;
    cfg_nack = 1'b0;
    rom[0] = w0; rom[1] = w1; rom[2] = w2; rom[3] = w3;
    fork
      monitor();
    join_none

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_pins", 64'({pwdn_n, mipi_reset_n}), 64'd0);
    check("rst_flags", 64'({busy, done, error, cfg_req}), 64'd0);
    check("rst_addr", 64'({rom_addr, err_index}), 64'd0);
    check("rst_cfg", 64'({cfg_dev, cfg_reg, cfg_data}), 64'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_hold", 64'({busy, pwdn_n, mipi_reset_n}), 64'd0);

    // Release timing and three writes ending at the last flag
    exp_q.push_back(w0[38:0]);
    exp_q.push_back(w1[38:0]);
    exp_q.push_back(w2[38:0]);
    base = npulse;
    pulse_start();
    wait_sig(0, 4, "busy_rise", tb);
    wait_sig(1, 20, "pwdn_rise", tp);
    check("pwdn_time", 64'(tp - tb), 64'd4);
    wait_sig(2, 20, "mrst_rise", tm);
    check("mrst_time", 64'(tm - tp), 64'd4);
    wait_sig(3, 40, "req_rise", tr);
    check("req_time", 64'(tr - tm), 64'(8 + 2));
    check("req_addr0", 64'(rom_addr), 64'd0);
    wait_sig(4, 200, "done3", n);
    check("done3_flags", 64'({done, busy, error}), 64'b100);
    check("done3_pulses", 64'(npulse - base), 64'd3);
    check("done3_pins", 64'({pwdn_n, mipi_reset_n}), 64'b11);

    // Delay entry of 2*1024 clocks between entries 0 and 2
    rom[1] = dly;
    exp_q.push_back(w0[38:0]);
    exp_q.push_back(w2[38:0]);
    base = npulse;
    pulse_start();
    check("restart_flags", 64'({busy, done}), 64'b10);
    wait_pulses(base + 2, 2400, "dly_pulses");
    // ack edge -> FETCH,LATCH(1) -> 2048 DELAY -> FETCH,LATCH(2) -> ISSUE
    check("dly_time", 64'(last_rise - ack_cyc), 64'(2048 + 4));
    wait_sig(4, 100, "dly_done", n);
    check("dly_pulses_tot", 64'(npulse - base), 64'd2);

    // Entry 1 NACKed repeatedly
    rom[1] = w1;
    exp_q.push_back(w0[38:0]);
    script.push_back(0);
`ifdef D8M_SEQ_RETRY_EN
    repeat (4) begin
      exp_q.push_back(w1[38:0]);
      script.push_back(1);
    end
`else
    exp_q.push_back(w1[38:0]);
    script.push_back(1);
`endif
    base = npulse;
    pulse_start();
    wait_sig(5, 300, "nack_err", n);
    check("nack_flags", 64'({error, busy, done}), 64'b100);
    check("nack_index", 64'(err_index), 64'd1);
    check("nack_pins", 64'({pwdn_n, mipi_reset_n}), 64'b11);
`ifdef D8M_SEQ_RETRY_EN
    check("nack_pulses", 64'(npulse - base), 64'd4 + 64'd1);
`else
    check("nack_pulses", 64'(npulse - base), 64'd1 + 64'd1);
`endif

    // Simultaneous ack+nack on entry 0
    exp_q.push_back(w0[38:0]);
    script.push_back(2);
`ifdef D8M_SEQ_RETRY_EN
    exp_q.push_back(w0[38:0]);
    exp_q.push_back(w1[38:0]);
    exp_q.push_back(w2[38:0]);
`endif
    base = npulse;
    pulse_start();
    check("both_clear", 64'({error, err_index}), 64'd0);
`ifdef D8M_SEQ_RETRY_EN
    wait_sig(4, 300, "both_done", n);
    check("both_pulses", 64'(npulse - base), 64'd4);
`else
    wait_sig(5, 300, "both_err", n);
    check("both_index", 64'(err_index), 64'd0);
    check("both_pulses", 64'(npulse - base), 64'd1);
`endif

    // Reset while a request is outstanding
    exp_q.push_back(w0[38:0]);
    pulse_start();
    wait_sig(3, 60, "rst_req", n);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_req", 64'(cfg_req), 64'd0);
    check("arst_pins", 64'({pwdn_n, mipi_reset_n}), 64'd0);
    check("arst_flags", 64'({busy, done, error}), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // No last flag: all four entries, no wrap, start while busy
    rom[2] = w2n;
    exp_q.push_back(w0[38:0]);
    exp_q.push_back(w1[38:0]);
    exp_q.push_back(w2n[38:0]);
    exp_q.push_back(w3[38:0]);
    base = npulse;
    pulse_start();
    wait_pulses(base + 1, 60, "full_first");
    pulse_start();
    @(negedge clk);
    check("busy_start", 64'({busy, pwdn_n, mipi_reset_n}), 64'b111);
    wait_sig(4, 300, "full_done", n);
    repeat (3) @(negedge clk);
    check("full_pulses", 64'(npulse - base), 64'd4);
    check("full_addr", 64'(rom_addr), 64'd3);
    check("full_flags", 64'({done, busy, error}), 64'b100);

    check("sb_empty", 64'(exp_q.size()), 64'd0);
    check("script_empty", 64'(script.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
